// File: rtl/sudoku_pkg.sv
// Shared constants, FSM encoding and board geometry for the sudoku board checker.
package sudoku_pkg;

   localparam int N_CELLS  = 81;
   localparam int N_GROUPS = 27;
   localparam int CELL_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Groups 0..8 are rows, 9..17 columns, 18..26 row-major 3x3 boxes.
   function automatic int cell_idx(input logic [4:0] grp, input int k);
      int b;
      if (grp > 5'd26) return 0;
      if (grp < 5'd9) return int'(grp) * 9 + k;
      if (grp < 5'd18) return k * 9 + (int'(grp) - 9);
      b = int'(grp) - 18;
      return (b / 3) * 27 + (b % 3) * 3 + (k / 3) * 9 + (k % 3);
   endfunction

endpackage

// File: rtl/group_eval.sv
// Combinational evaluation of one 9-cell group: duplicate digit, empty cell, invalid cell.
module group_eval
   import sudoku_pkg::*;
(
   input  logic [8:0][CELL_W-1:0] cells,
   output logic                   dup,
   output logic                   has_empty,
   output logic                   has_invalid
);

   logic [15:0] seen;

   always_comb begin
      // NOTE: blocking assignments here model a sequential walk over the cells;
      // every variable gets a default first so no latch is inferred.
      seen        = '0;
      dup         = 1'b0;
      has_empty   = 1'b0;
      has_invalid = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (cells[k] == 4'd0) begin
            has_empty = 1'b1;
         end else if (cells[k] > 4'd9) begin
            has_invalid = 1'b1;
         end else begin
            if (seen[cells[k]]) dup = 1'b1;
            seen[cells[k]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_checker.sv
// Sudoku board checker: snapshots the board, scans 27 groups one per cycle, reports win/conflict/full.
module board_checker
   import sudoku_pkg::*;
(
   input  logic                      CLK_100MHz,
   input  logic                      RST,
   input  logic [N_CELLS*CELL_W-1:0] cur_map,
   input  logic                      inited,
   output logic                      win_tag,
   output logic                      conflict_tag,
   output logic                      full_tag,
   output logic                      busy,
   output logic                      check_done
);

   localparam logic [4:0] LAST_GROUP = 5'(N_GROUPS - 1);

   state_t                    state, state_nx;
   logic [N_CELLS*CELL_W-1:0] snap;
   logic [4:0]                g;
   logic                      pending, inited_q;
   logic                      dup_acc, empty_acc, invalid_acc;
   logic                      start, finish;
   logic [8:0][CELL_W-1:0]    grp_cells;
   logic                      grp_dup, grp_empty, grp_invalid;

   always_comb begin
      for (int k = 0; k < 9; k++)
         grp_cells[k] = snap[cell_idx(g, k)*CELL_W +: CELL_W];
   end

   group_eval u_group_eval (
      .cells       (grp_cells),
      .dup         (grp_dup),
      .has_empty   (grp_empty),
      .has_invalid (grp_invalid)
   );

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      finish   = 1'b0;
      // Dropping inited aborts everything and outranks a trigger.
      if (!inited) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: if (cur_map != snap || pending) begin
               start    = 1'b1;
               state_nx = SCAN;
            end
            SCAN: if (g == LAST_GROUP) state_nx = DONE;
            DONE: begin
               finish   = 1'b1;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_100MHz or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge CLK_100MHz or posedge RST) begin
      if (RST) begin
         // NOTE: the snapshot is an ordinary register, not a memory, so it is reset
         // to zero; pending starts set so the first scan happens once inited rises.
         snap         <= '0;
         g            <= '0;
         pending      <= 1'b1;
         inited_q     <= 1'b0;
         dup_acc      <= 1'b0;
         empty_acc    <= 1'b0;
         invalid_acc  <= 1'b0;
         win_tag      <= 1'b0;
         conflict_tag <= 1'b0;
         full_tag     <= 1'b0;
         busy         <= 1'b0;
         check_done   <= 1'b0;
      end else begin
         inited_q   <= inited;
         check_done <= 1'b0;
         if (start)                pending <= 1'b0;
         else if (inited && !inited_q) pending <= 1'b1;

         if (!inited) begin
            busy         <= 1'b0;
            win_tag      <= 1'b0;
            conflict_tag <= 1'b0;
            full_tag     <= 1'b0;
         end else if (start) begin
            snap        <= cur_map;
            g           <= '0;
            busy        <= 1'b1;
            dup_acc     <= 1'b0;
            empty_acc   <= 1'b0;
            invalid_acc <= 1'b0;
         end else if (state == SCAN) begin
            dup_acc     <= dup_acc | grp_dup;
            empty_acc   <= empty_acc | grp_empty;
            invalid_acc <= invalid_acc | grp_invalid;
            g           <= g + 5'd1;
         end else if (finish) begin
            conflict_tag <= dup_acc | invalid_acc;
            full_tag     <= !empty_acc;
            win_tag      <= !empty_acc && !dup_acc && !invalid_acc;
            check_done   <= 1'b1;
            busy         <= 1'b0;
         end
      end
   end

endmodule
